// File: rtl/high_to_low_pkg.sv
// high_to_low_pkg: shared definitions for the wide-to-narrow stream converter.
// Holds the FSM state encoding, the wide-word width derivation and the
// beat-number to slice-number mapping used for LSB/MSB-first ordering.
package high_to_low_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t SEND = 1'b1;

  // Wide word width: one narrow beat times the maximum number of beats.
  function automatic int calc_high_width(input int low_width, input int burst_log);
    return low_width * (1 << burst_log);
  endfunction

  // Slice carried by beat k: counts up from slice 0 for LSB-first words,
  // counts down from slice len for MSB-first words.
  function automatic int slice_index(input int k, input int len, input logic msb_first);
    return msb_first ? (len - k) : k;
  endfunction

endpackage

// File: rtl/high_to_low_slice_sel.sv
// high_to_low_slice_sel: combinational mux that picks the narrow slice of a
// wide word carried by a given beat, honouring the word's length and order.
module high_to_low_slice_sel
  import high_to_low_pkg::*;
#(
  parameter int  LOW_DATA_WIDTH = 32,
  parameter int  BRUST_SIZE_LOG = 2,
  localparam int BEATS          = 1 << BRUST_SIZE_LOG,
  localparam int HIGH_WIDTH     = calc_high_width(LOW_DATA_WIDTH, BRUST_SIZE_LOG)
) (
  input  logic [HIGH_WIDTH-1:0]     word,
  input  logic [BRUST_SIZE_LOG-1:0] index,
  input  logic [BRUST_SIZE_LOG-1:0] len,
  input  logic                      msb_first,
  output logic [LOW_DATA_WIDTH-1:0] beat
);

  logic [LOW_DATA_WIDTH-1:0] slices [BEATS];
  logic [BRUST_SIZE_LOG-1:0] sel;

  // Split the word into slices, map the beat number to a slice, select it.
  always_comb begin
    for (int i = 0; i < BEATS; i++) begin
      slices[i] = word[i*LOW_DATA_WIDTH +: LOW_DATA_WIDTH];
    end
    sel  = BRUST_SIZE_LOG'(slice_index(int'(index), int'(len), msb_first));
    beat = slices[sel];
  end

endmodule

// File: rtl/high_to_low_stream.sv
// high_to_low_stream: wide-to-narrow bus converter. Takes one wide word per
// handshake and emits 1..2**BRUST_SIZE_LOG narrow beats, LSB- or MSB-first,
// with a last-beat flag and a one-word skid buffer so back-to-back words flow
// without bubbles under backpressure. All narrow-side outputs are flops.
// Optional macro HIGH_TO_LOW_PERF_CNT_EN adds perf_beat_cnt (wrapping count of
// narrow handshakes) and perf_stall_cnt (saturating count of stalled cycles).
module high_to_low_stream
  import high_to_low_pkg::*;
#(
  parameter int  LOW_DATA_WIDTH = 32,
  parameter int  BRUST_SIZE_LOG = 2,
  localparam int HIGH_WIDTH     = calc_high_width(LOW_DATA_WIDTH, BRUST_SIZE_LOG)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [HIGH_WIDTH-1:0]     high_read_data,
  input  logic [BRUST_SIZE_LOG-1:0] high_read_len,
  input  logic                      high_read_msb_first,
  input  logic                      high_read_valid,
  output logic                      high_read_ready,
  output logic                      high_read_finish,
  output logic [LOW_DATA_WIDTH-1:0] low_write_data,
  output logic                      low_write_valid,
  output logic                      low_write_last,
  input  logic                      low_write_ready
`ifdef HIGH_TO_LOW_PERF_CNT_EN
  ,
  output logic [31:0]               perf_beat_cnt,
  output logic [31:0]               perf_stall_cnt
`endif
);

  state_t                    state_q, state_d;
  logic [HIGH_WIDTH-1:0]     cur_data_q, cur_data_d;
  logic [BRUST_SIZE_LOG-1:0] cur_len_q, cur_len_d;
  logic                      cur_msb_q, cur_msb_d;
  logic [BRUST_SIZE_LOG-1:0] idx_q, idx_d;
  logic [HIGH_WIDTH-1:0]     skid_data_q, skid_data_d;
  logic [BRUST_SIZE_LOG-1:0] skid_len_q, skid_len_d;
  logic                      skid_msb_q, skid_msb_d;
  logic                      skid_full_q, skid_full_d;
  logic                      finish_d;
  logic                      valid_d;
  logic                      last_d;
  logic [LOW_DATA_WIDTH-1:0] beat_d;
  logic                      word_acc;
  logic                      beat_hs;

  assign high_read_ready = ~skid_full_q;
  assign word_acc        = high_read_valid && high_read_ready;
  assign beat_hs         = low_write_valid && low_write_ready;

  // Next-state logic: load current from input or skid, advance the beat index.
  always_comb begin
    state_d     = state_q;
    cur_data_d  = cur_data_q;
    cur_len_d   = cur_len_q;
    cur_msb_d   = cur_msb_q;
    idx_d       = idx_q;
    skid_data_d = skid_data_q;
    skid_len_d  = skid_len_q;
    skid_msb_d  = skid_msb_q;
    skid_full_d = skid_full_q;
    finish_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (word_acc) begin
          cur_data_d = high_read_data;
          cur_len_d  = high_read_len;
          cur_msb_d  = high_read_msb_first;
          idx_d      = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (beat_hs && low_write_last) begin
          finish_d = 1'b1;
          idx_d    = '0;
          if (skid_full_q) begin
            cur_data_d  = skid_data_q;
            cur_len_d   = skid_len_q;
            cur_msb_d   = skid_msb_q;
            skid_full_d = 1'b0;
          end else if (word_acc) begin
            cur_data_d = high_read_data;
            cur_len_d  = high_read_len;
            cur_msb_d  = high_read_msb_first;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (beat_hs) begin
            idx_d = idx_q + 1'b1;
          end
          if (word_acc) begin
            skid_data_d = high_read_data;
            skid_len_d  = high_read_len;
            skid_msb_d  = high_read_msb_first;
            skid_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == SEND);
    last_d  = (idx_d == cur_len_d);
  end

  // The mux looks at next-cycle contents of the current register so each
  // beat can be captured straight into the output flop with no bubble.
  high_to_low_slice_sel #(
    .LOW_DATA_WIDTH (LOW_DATA_WIDTH),
    .BRUST_SIZE_LOG (BRUST_SIZE_LOG)
  ) u_slice_sel (
    .word      (cur_data_d),
    .index     (idx_d),
    .len       (cur_len_d),
    .msb_first (cur_msb_d),
    .beat      (beat_d)
  );

  // State, storage and registered narrow-side outputs; reset drops all words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cur_data_q       <= '0;
      cur_len_q        <= '0;
      cur_msb_q        <= 1'b0;
      idx_q            <= '0;
      skid_data_q      <= '0;
      skid_len_q       <= '0;
      skid_msb_q       <= 1'b0;
      skid_full_q      <= 1'b0;
      low_write_valid  <= 1'b0;
      low_write_last   <= 1'b0;
      low_write_data   <= '0;
      high_read_finish <= 1'b0;
    end else begin
      state_q          <= state_d;
      cur_data_q       <= cur_data_d;
      cur_len_q        <= cur_len_d;
      cur_msb_q        <= cur_msb_d;
      idx_q            <= idx_d;
      skid_data_q      <= skid_data_d;
      skid_len_q       <= skid_len_d;
      skid_msb_q       <= skid_msb_d;
      skid_full_q      <= skid_full_d;
      low_write_valid  <= valid_d;
      low_write_last   <= last_d;
      low_write_data   <= beat_d;
      high_read_finish <= finish_d;
    end
  end

`ifdef HIGH_TO_LOW_PERF_CNT_EN
  // Count handshaked beats (wrapping) and stalled beat cycles (saturating).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_beat_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (beat_hs) begin
        perf_beat_cnt <= perf_beat_cnt + 32'd1;
      end
      if (low_write_valid && !low_write_ready && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_high_to_low_stream.sv
// tb_high_to_low_stream: self-checking bench for high_to_low_stream.
// Expected beats come from a queue model: every accepted wide word is expanded
// into its narrow beats in order; every narrow handshake pops and compares.
module tb_high_to_low_stream;

  localparam int LW  = 32;
  localparam int LOG = 2;
  localparam int HW  = LW << LOG;

  typedef struct packed {
    logic [LW-1:0] data;
    logic          last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [HW-1:0]  high_read_data;
  logic [LOG-1:0] high_read_len;
  logic           high_read_msb_first;
  logic           high_read_valid;
  logic           high_read_ready;
  logic           high_read_finish;
  logic [LW-1:0]  low_write_data;
  logic           low_write_valid;
  logic           low_write_last;
  logic           low_write_ready;
`ifdef HIGH_TO_LOW_PERF_CNT_EN
  logic [31:0]    perf_beat_cnt;
  logic [31:0]    perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  beat_t         exp_q[$];
  logic          obs_valid, obs_last, obs_finish, obs_hready;
  logic [LW-1:0] obs_data;
  logic          beat_hs, word_acc;
  logic [LW-1:0] got_data, exp_data_b;
  logic          got_last, exp_last_b;
  logic          exp_finish = 1'b0;

  localparam logic [HW-1:0] W1 = 128'h44444444_33333333_22222222_11111111;

  high_to_low_stream #(
    .LOW_DATA_WIDTH (LW),
    .BRUST_SIZE_LOG (LOG)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .high_read_data      (high_read_data),
    .high_read_len       (high_read_len),
    .high_read_msb_first (high_read_msb_first),
    .high_read_valid     (high_read_valid),
    .high_read_ready     (high_read_ready),
    .high_read_finish    (high_read_finish),
    .low_write_data      (low_write_data),
    .low_write_valid     (low_write_valid),
    .low_write_last      (low_write_last),
    .low_write_ready     (low_write_ready)
`ifdef HIGH_TO_LOW_PERF_CNT_EN
    ,
    .perf_beat_cnt       (perf_beat_cnt),
    .perf_stall_cnt      (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [HW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    obs_valid  = low_write_valid;
    obs_last   = low_write_last;
    obs_data   = low_write_data;
    obs_finish = high_read_finish;
    obs_hready = high_read_ready;
  endtask

  // Drive one cycle of inputs and update the reference model; no comparisons.
  task automatic step(input logic hv, input logic [HW-1:0] hd, input logic [LOG-1:0] hl,
                      input logic hm, input logic lr);
    beat_t b;
    logic  fin;
    int    len_i;
    int    s;
    high_read_valid     = hv;
    high_read_data      = hd;
    high_read_len       = hl;
    high_read_msb_first = hm;
    low_write_ready     = lr;
    beat_hs    = obs_valid && lr;
    word_acc   = hv && obs_hready;
    got_data   = obs_data;
    got_last   = obs_last;
    fin        = 1'b0;
    exp_data_b = '1;
    exp_last_b = 1'bx;
    if (beat_hs && exp_q.size() > 0) begin
      b = exp_q.pop_front();
      exp_data_b = b.data;
      exp_last_b = b.last;
      fin        = b.last;
    end
    if (word_acc) begin
      len_i = int'(hl);
      for (int k = 0; k <= len_i; k++) begin
        s      = hm ? (len_i - k) : k;
        b.data = hd[s*LW +: LW];
        b.last = (k == len_i);
        exp_q.push_back(b);
      end
    end
    tick();
    exp_finish = fin;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    high_read_valid = 1'b0;
    high_read_data = '0;
    high_read_len = '0;
    high_read_msb_first = 1'b0;
    low_write_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({obs_valid, obs_last, obs_finish} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b required 000", {obs_valid, obs_last, obs_finish});
    end
    checks++;
    if (obs_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h required 0", obs_data);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs_hready !== 1'b1 || obs_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release got ready %b valid %b required 1 0", obs_hready, obs_valid);
    end
    exp_q.delete();
    exp_finish = 1'b0;
  endtask

  task automatic test_lsb_full();
    step(1'b1, W1, 2'd3, 1'b0, 1'b1);
    checks++;
    if (obs_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lsb_latency got valid %b required 1", obs_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      checks++;
      if (!beat_hs || got_data !== exp_data_b || got_last !== exp_last_b) begin
        errors++;
        $display("[TB] FAIL lsb_beat%0d got %h last %b required %h last %b", i, got_data, got_last, exp_data_b, exp_last_b);
      end
      checks++;
      if (obs_finish !== exp_finish) begin
        errors++;
        $display("[TB] FAIL lsb_finish%0d got %b required %b", i, obs_finish, exp_finish);
      end
    end
    checks++;
    if (obs_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL lsb_end got valid %b pending %0d required 0 0", obs_valid, exp_q.size());
    end
  endtask

  task automatic test_msb_partial();
    step(1'b1, W1, 2'd1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      checks++;
      if (!beat_hs || got_data !== exp_data_b || got_last !== exp_last_b) begin
        errors++;
        $display("[TB] FAIL msb_beat%0d got %h last %b required %h last %b", i, got_data, got_last, exp_data_b, exp_last_b);
      end
      checks++;
      if (obs_finish !== exp_finish) begin
        errors++;
        $display("[TB] FAIL msb_finish%0d got %b required %b", i, obs_finish, exp_finish);
      end
    end
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL msb_end got valid %b required 0", obs_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [HW-1:0] wd [2];
    int            nxt;
    int            fin_at[$];
    wd[0] = rand_word();
    wd[1] = rand_word();
    nxt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i >= 1 && i <= 8) begin
        checks++;
        if (obs_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_gap cycle %0d got valid %b required 1", i, obs_valid);
        end
      end
      step(nxt < 2, wd[nxt % 2], 2'd3, 1'b0, 1'b1);
      if (word_acc) nxt++;
      if (beat_hs) begin
        checks++;
        if (got_data !== exp_data_b || got_last !== exp_last_b) begin
          errors++;
          $display("[TB] FAIL b2b_beat got %h last %b required %h last %b", got_data, got_last, exp_data_b, exp_last_b);
        end
      end
      checks++;
      if (obs_finish !== exp_finish) begin
        errors++;
        $display("[TB] FAIL b2b_finish got %b required %b", obs_finish, exp_finish);
      end
      if (obs_finish) fin_at.push_back(i);
    end
    checks++;
    if (fin_at.size() != 2 || (fin_at[1] - fin_at[0]) != 4) begin
      errors++;
      $display("[TB] FAIL b2b_spacing got %0d pulses required 2 pulses 4 apart", fin_at.size());
    end
  endtask

  task automatic test_backpressure();
    logic [HW-1:0] wd [3];
    logic [LW-1:0] hold_val;
    logic          saw_drop;
    logic          lr;
    int            nxt;
    for (int j = 0; j < 3; j++) wd[j] = rand_word();
    nxt = 0;
    saw_drop = 1'b0;
    hold_val = '0;
    for (int i = 0; i < 40; i++) begin
      lr = !(i >= 2 && i < 7);
      if (i == 2) hold_val = obs_data;
      if (i >= 3 && i < 7) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== hold_val) begin
          errors++;
          $display("[TB] FAIL bp_hold cycle %0d got %h valid %b required %h valid 1", i, obs_data, obs_valid, hold_val);
        end
      end
      step((nxt < 3) && (i == 0 || i >= 2), wd[nxt % 3], (nxt == 2) ? 2'd2 : 2'd3, nxt == 2, lr);
      if (word_acc) nxt++;
      if (!obs_hready) saw_drop = 1'b1;
      if (beat_hs) begin
        checks++;
        if (got_data !== exp_data_b || got_last !== exp_last_b) begin
          errors++;
          $display("[TB] FAIL bp_beat got %h last %b required %h last %b", got_data, got_last, exp_data_b, exp_last_b);
        end
      end
      checks++;
      if (obs_finish !== exp_finish) begin
        errors++;
        $display("[TB] FAIL bp_finish got %b required %b", obs_finish, exp_finish);
      end
    end
    checks++;
    if (saw_drop !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_ready_drop got %b required 1", saw_drop);
    end
    checks++;
    if (nxt != 3 || exp_q.size() != 0 || obs_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drain got words %0d pending %0d required 3 0", nxt, exp_q.size());
    end
  endtask

  task automatic test_single_beats();
    logic [HW-1:0] wd [3];
    int            nxt;
    for (int j = 0; j < 3; j++) wd[j] = rand_word();
    nxt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i >= 1 && i <= 3) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_last !== 1'b1) begin
          errors++;
          $display("[TB] FAIL single_stream cycle %0d got valid %b last %b required 1 1", i, obs_valid, obs_last);
        end
      end
      step(nxt < 3, wd[nxt % 3], 2'd0, 1'b0, 1'b1);
      if (word_acc) nxt++;
      if (beat_hs) begin
        checks++;
        if (got_data !== exp_data_b || got_last !== exp_last_b) begin
          errors++;
          $display("[TB] FAIL single_beat got %h last %b required %h last %b", got_data, got_last, exp_data_b, exp_last_b);
        end
      end
      checks++;
      if (obs_finish !== exp_finish) begin
        errors++;
        $display("[TB] FAIL single_finish got %b required %b", obs_finish, exp_finish);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, rand_word(), 2'd3, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, rand_word(), 2'd3, 1'b1, 1'b0);
    checks++;
    if (word_acc !== 1'b1 || obs_hready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rmid_skid got acc %b ready %b required 1 0", word_acc, obs_hready);
    end
    high_read_valid = 1'b0;
    low_write_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    exp_finish = 1'b0;
    checks++;
    if (obs_valid !== 1'b0 || obs_hready !== 1'b1 || obs_finish !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rmid_flush got valid %b ready %b finish %b required 0 1 0", obs_valid, obs_hready, obs_finish);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs_finish !== 1'b0 || obs_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rmid_after got finish %b valid %b required 0 0", obs_finish, obs_valid);
    end
    step(1'b1, rand_word(), 2'd2, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      if (beat_hs) begin
        checks++;
        if (got_data !== exp_data_b || got_last !== exp_last_b) begin
          errors++;
          $display("[TB] FAIL rmid_beat got %h last %b required %h last %b", got_data, got_last, exp_data_b, exp_last_b);
        end
      end
      checks++;
      if (obs_finish !== exp_finish) begin
        errors++;
        $display("[TB] FAIL rmid_finish got %b required %b", obs_finish, exp_finish);
      end
    end
  endtask

  task automatic test_random();
    logic [HW-1:0]  wd [25];
    logic [LOG-1:0] wl [25];
    logic           wm [25];
    logic [LW-1:0]  prev_data;
    logic           prev_stall;
    logic           lr;
    int             nxt;
    int             gap;
    int             cyc;
    for (int j = 0; j < 25; j++) begin
      wd[j] = rand_word();
      wl[j] = LOG'($urandom_range(0, 3));
      wm[j] = 1'($urandom_range(0, 1));
    end
    nxt = 0;
    gap = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    while (cyc < 600 && !(nxt == 25 && exp_q.size() == 0 && obs_valid === 1'b0)) begin
      if (prev_stall) begin
        checks++;
        if (obs_data !== prev_data || obs_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL rand_hold got %h valid %b required %h valid 1", obs_data, obs_valid, prev_data);
        end
      end
      lr = ($urandom_range(0, 3) != 0);
      prev_stall = obs_valid && !lr;
      prev_data = obs_data;
      step((nxt < 25) && (gap == 0), wd[nxt % 25], wl[nxt % 25], wm[nxt % 25], lr);
      if (word_acc) begin
        nxt++;
        gap = $urandom_range(0, 2);
      end else if (gap > 0 && !high_read_valid) begin
        gap--;
      end
      if (beat_hs) begin
        checks++;
        if (got_data !== exp_data_b || got_last !== exp_last_b) begin
          errors++;
          $display("[TB] FAIL rand_beat got %h last %b required %h last %b", got_data, got_last, exp_data_b, exp_last_b);
        end
      end
      checks++;
      if (obs_finish !== exp_finish) begin
        errors++;
        $display("[TB] FAIL rand_finish got %b required %b", obs_finish, exp_finish);
      end
      cyc++;
    end
    checks++;
    if (nxt != 25 || exp_q.size() != 0 || obs_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rand_drain got words %0d pending %0d required 25 0", nxt, exp_q.size());
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_lsb_full();
    test_msb_partial();
    test_back_to_back();
    test_backpressure();
    test_single_beats();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
